// File: rtl/seq_divider.sv
// Multicycle signed restoring divider (MIPS div semantics): one quotient bit per clock, sign fix in a final cycle.
// Optional build macro SEQ_DIVIDER_EARLY_EXIT_EN skips the iterations when |a| < |b|.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] hi,
    output logic signed [WIDTH-1:0] lo,
    output logic                    div_zero,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem, quo, divisor;
    logic             sign_q, sign_r;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_zero, early;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic neg);
        return neg ? (~m + WIDTH'(1)) : m;
    endfunction

    // Magnitudes are unsigned, so the most negative value maps onto itself and stays valid.
    assign a_mag  = apply_sign(a, a[WIDTH-1]);
    assign b_mag  = apply_sign(b, b[WIDTH-1]);
    assign b_zero = (b == '0);

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor});
    assign diff    = shifted[WIDTH-1:0] - divisor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start && !b_zero) state_next = early ? FIX : RUN;
            RUN:  if (count == CNT_W'(1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (b_zero) begin
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r  <= a[WIDTH-1];
                            divisor <= b_mag;
                            count   <= CNT_W'(WIDTH);
                            // Early exit parks |a| as the remainder with a zero quotient.
                            rem     <= early ? a_mag : '0;
                            quo     <= early ? '0 : a_mag;
                        end
                    end
                end
                RUN: begin
                    rem   <= fits ? diff : shifted[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], fits};
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    lo   <= apply_sign(quo, sign_q);
                    hi   <= apply_sign(rem, sign_r);
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
